// File: rtl/seg_scan_ctrl.sv
// Two-digit seven-segment scan controller: latches a value, converts it to BCD
// (double-dabble) or splits hex nibbles, and time-multiplexes both digits.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV  = 12000,
    parameter int BLANK_CYCLES = 16,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] value,
    input  logic       hex_mode,
    input  logic       update,
    output logic       busy,
    output logic [6:0] seg,
    output logic [1:0] dig_en
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic {
        ST_SHOW,
        ST_CONVERT
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [19:0] r_shift, w_shift_nxt, w_dab;
    logic [2:0]  r_step, w_step_nxt;
    logic [3:0]  r_ms, r_ls, w_ms_nxt, w_ls_nxt;
    logic        r_hex, w_hex_nxt;

    logic [CW-1:0] r_cnt;
    logic          r_slot;
    logic [6:0]    r_seg;
    logic [1:0]    r_dig;
    logic [3:0]    w_digit;
    logic          w_show;

    // Shift register layout: {hundreds, tens, ones, binary[7:0]}.
    function automatic logic [19:0] dabble_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        for (int i = 0; i < 3; i++) begin
            if (t[8 + 4*i +: 4] >= 4'd5) t[8 + 4*i +: 4] = t[8 + 4*i +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'h0: decode = 7'h3F;
            4'h1: decode = 7'h06;
            4'h2: decode = 7'h5B;
            4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;
            4'h5: decode = 7'h6D;
            4'h6: decode = 7'h7D;
            4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;
            4'h9: decode = 7'h6F;
            4'hA: decode = 7'h77;
            4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;
            4'hD: decode = 7'h5E;
            4'hE: decode = 7'h79;
            default: decode = 7'h71;
        endcase
    endfunction

    assign w_dab = dabble_step(r_shift);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_step_nxt  = r_step;
        w_ms_nxt    = r_ms;
        w_ls_nxt    = r_ls;
        w_hex_nxt   = r_hex;
        case (r_state)
            ST_SHOW: begin
                if (update) begin
                    if (hex_mode) begin
                        w_ms_nxt  = value[7:4];
                        w_ls_nxt  = value[3:0];
                        w_hex_nxt = 1'b1;
                    end else begin
                        w_shift_nxt = {12'd0, value};
                        w_step_nxt  = 3'd0;
                        w_state_nxt = ST_CONVERT;
                    end
                end
            end
            ST_CONVERT: begin
                w_shift_nxt = w_dab;
                w_step_nxt  = r_step + 3'd1;
                if (r_step == 3'd7) begin
                    // Display mode switches together with the digits so old digits never show in dec style.
                    w_state_nxt = ST_SHOW;
                    w_hex_nxt   = 1'b0;
                    w_ms_nxt    = (w_dab[19:16] != 4'd0) ? 4'd0 : w_dab[15:12];
                    w_ls_nxt    = (w_dab[19:16] != 4'd0) ? 4'd0 : w_dab[11:8];
                end
            end
            default: w_state_nxt = ST_SHOW;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_SHOW;
            r_shift <= '0;
            r_step  <= '0;
            r_ms    <= '0;
            r_ls    <= '0;
            r_hex   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_step  <= w_step_nxt;
            r_ms    <= w_ms_nxt;
            r_ls    <= w_ls_nxt;
            r_hex   <= w_hex_nxt;
        end
    end

    // Leading-zero blank applies to the MS digit only in dec mode.
    assign w_digit = r_slot ? r_ms : r_ls;
    assign w_show  = (r_cnt >= CW'(BLANK_CYCLES)) && (!r_slot || r_hex || (r_ms != 4'd0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_slot <= 1'b0;
            r_seg  <= '0;
            r_dig  <= '0;
        end else begin
            if (r_cnt == CW'(REFRESH_DIV - 1)) begin
                r_cnt  <= '0;
                r_slot <= ~r_slot;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_dig <= w_show ? (r_slot ? 2'b10 : 2'b01) : 2'b00;
            r_seg <= w_show ? decode(w_digit) : 7'd0;
        end
    end

    assign busy   = (r_state == ST_CONVERT);
    assign seg    = ACTIVE_LOW ? ~r_seg : r_seg;
    assign dig_en = ACTIVE_LOW ? ~r_dig : r_dig;

endmodule
